camera_pixel_capture: RTL and testbench

- Transmit-side source for the 16-bit pixel stream: turns the OV7670 8-bit DVP bus (cam_pclk, cam_vsync, cam_href, cam_data) into RGB565 words.
- Each word is presented as a one-cycle pixel_valid pulse with pixel_out and a linear frame-buffer address.
- Sits between the camera pins and every pixelValid/pixelIn consumer (pixel buffers, frame-buffer write port, detection pipeline).
- All logic runs on the system clock; camera signals are oversampled, not used as clocks.

---
 rtl/cam_pkg.sv | 11 +
 rtl/cam_sync_edge.sv | 30 +++
 rtl/camera_pixel_capture.sv | 126 ++++++++++++
 tb/tb_camera_pixel_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants for the camera capture path: default image geometry,
// pixel width and the capture FSM encoding.
package cam_pkg;
  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
// q is the synchronized (s2) value; rise/fall compare s2 against s3.
module cam_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/camera_pixel_capture.sv
// Oversamples the OV7670 DVP bus on the system clock and assembles byte pairs
// into RGB565 pixels, each issued as a one-cycle strobe with a linear address.
module camera_pixel_capture
  import cam_pkg::PIX_W, cam_pkg::ST_IDLE, cam_pkg::ST_ACTIVE;
#(
  parameter int IMG_W  = cam_pkg::IMG_W,
  parameter int IMG_H  = cam_pkg::IMG_H,
  parameter int ADDR_W = cam_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pixel_valid,
  output logic [PIX_W-1:0]  pixel_out,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  // One extra count bit so an over-long frame stays distinguishable from a full one.
  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(IMG_W * IMG_H);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Control bits packed as {pclk, vsync, href}.
  logic [2:0] ctl_q, ctl_rise, ctl_fall;
  logic [7:0] data_q, data_rise, data_fall;

  cam_sync_edge #(.W(3)) u_ctl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({cam_pclk, cam_vsync, cam_href}),
    .q    (ctl_q),
    .rise (ctl_rise),
    .fall (ctl_fall)
  );

  cam_sync_edge #(.W(8)) u_data_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cam_data),
    .q    (data_q),
    .rise (data_rise),
    .fall (data_fall)
  );

  logic pclk_rise, vsync_rise, vsync_fall, href_s;
  assign pclk_rise  = ctl_rise[2];
  assign vsync_rise = ctl_rise[1];
  assign vsync_fall = ctl_fall[1];
  assign href_s     = ctl_q[0];

  logic unused_sync;
  assign unused_sync = ^{ctl_q[2:1], ctl_rise[0], ctl_fall[2], ctl_fall[0], data_rise, data_fall};

  logic [0:0]       state;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      hi_byte     <= '0;
      count       <= '0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      pixel_addr  <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vsync_fall && capture_en) begin
            state      <= ST_ACTIVE;
            pixel_addr <= '0;
            phase      <= 1'b0;
            count      <= '0;
          end
        end
        default: begin
          // Frame end takes priority over a coincident byte.
          if (vsync_rise) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            frame_done <= 1'b1;
            frame_err  <= (count != TOTAL);
          end else if (!href_s) begin
            phase <= 1'b0;
          end else if (pclk_rise) begin
            if (!phase) begin
              hi_byte <= data_q;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (count < TOTAL) begin
                pixel_out   <= {hi_byte, data_q};
                pixel_addr  <= count[ADDR_W-1:0];
                pixel_valid <= 1'b1;
              end
              if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_ACTIVE);
endmodule

// File: tb/tb_camera_pixel_capture.sv
// Drives DVP frames with a 4x oversampled pixel clock and checks the pixel
// stream and frame status against a line/byte-level model of the capture rules.
module tb_camera_pixel_capture;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 19;
  localparam int TOTAL  = IMG_W * IMG_H;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              capture_en = 1'b0;
  logic              cam_pclk = 1'b0;
  logic              cam_vsync = 1'b1;
  logic              cam_href = 1'b0;
  logic [7:0]        cam_data = 8'h00;
  logic              pixel_valid;
  logic [15:0]       pixel_out;
  logic [ADDR_W-1:0] pixel_addr;
  logic              busy, frame_done, frame_err;

  camera_pixel_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pixel_valid(pixel_valid),
    .pixel_out  (pixel_out),
    .pixel_addr (pixel_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard state: {addr, pixel} entries in issue order
  logic [ADDR_W+15:0] exp_q[$];
  logic [ADDR_W+15:0] last_exp;
  bit                 have_last;
  int                 cyc = 0;
  int                 rise2_cyc = 0;
  int                 done_cnt = 0;
  int                 err_cnt = 0;
  int                 exp_done = 0;
  int                 exp_err = 0;
  logic               prev_valid = 1'b0;
  bit                 seq_mode = 1'b0;
  logic [7:0]         seq_byte = 8'h12;
  int                 line_len[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [ADDR_W+15:0] e;
    if (pixel_valid) begin
      check("pv_width", 64'(prev_valid), 64'(0));
      check("latency", 64'(cyc - rise2_cyc), 64'(3));
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pixel", 64'({pixel_addr, pixel_out}), 64'(e));
      end
    end
    if (frame_done) done_cnt++;
    if (frame_err) begin
      err_cnt++;
      check("err_with_done", 64'(frame_done), 64'(1));
    end
    prev_valid = pixel_valid;
  end

  // driver tasks: one byte is 2 clk with pclk low, then 2 clk with pclk high
  task automatic cam_byte(input logic [7:0] b, input bit second);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_data = b;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    if (second) rise2_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic end_line();
    @(negedge clk);
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input bit en, input bit drop_mid);
    int pix;
    logic [7:0] b, hi;
    logic [ADDR_W+15:0] e;
    pix = 0;
    hi = 8'h00;
    have_last = 1'b0;
    @(negedge clk);
    capture_en = en;
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_start", 64'(busy), 64'(en));
    foreach (line_len[li]) begin
      cam_href = 1'b1;
      for (int k = 0; k < line_len[li]; k++) begin
        b = seq_mode ? seq_byte : 8'($urandom);
        seq_byte = seq_byte + 8'h22;
        cam_byte(b, k[0]);
        if (!k[0]) begin
          hi = b;
        end else begin
          if (en && pix < TOTAL) begin
            e = {ADDR_W'(pix), hi, b};
            exp_q.push_back(e);
            last_exp = e;
            have_last = 1'b1;
          end
          pix++;
        end
      end
      end_line();
      if (drop_mid) capture_en = 1'b0;
    end
    check("busy_mid", 64'(busy), 64'(en));
    cam_vsync = 1'b1;
    if (en) begin
      exp_done++;
      if (pix != TOTAL) exp_err++;
    end
    repeat (8) @(negedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'(0));
    check("busy_end", 64'(busy), 64'(0));
    check("frame_done_cnt", 64'(done_cnt), 64'(exp_done));
    check("frame_err_cnt", 64'(err_cnt), 64'(exp_err));
    if (have_last) check("hold_pixel", 64'({pixel_addr, pixel_out}), 64'(last_exp));
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    // reset with random camera activity
    reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cam_pclk   = 1'($urandom);
      cam_href   = 1'($urandom);
      cam_vsync  = 1'($urandom);
      cam_data   = 8'($urandom);
      capture_en = 1'b1;
      if (i == 10)
        check("rst_outputs_mid", 64'({pixel_valid, pixel_out, pixel_addr, busy, frame_done, frame_err}), 64'(0));
    end
    check("rst_outputs", 64'({pixel_valid, pixel_out, pixel_addr, busy, frame_done, frame_err}), 64'(0));

    // release mid-frame: the frame in progress must not be captured
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_pclk  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int ln = 0; ln < 2; ln++) begin
      cam_href = 1'b1;
      for (int k = 0; k < 8; k++) cam_byte(8'($urandom), k[0]);
      end_line();
    end
    check("busy_after_release", 64'(busy), 64'(0));
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_after_release", 64'(done_cnt), 64'(0));

    // tiny frame with sequential bytes 0x12, 0x34, ...
    seq_mode = 1'b1;
    seq_byte = 8'h12;
    line_len = {8, 8};
    run_frame(1'b1, 1'b0);
    seq_mode = 1'b0;

    line_len = {9, 8};      // odd line, dangling byte dropped
    run_frame(1'b1, 1'b0);
    line_len = {8, 6};      // short frame
    run_frame(1'b1, 1'b0);
    line_len = {8, 8, 4};   // long frame
    run_frame(1'b1, 1'b0);
    line_len = {8, 8};      // capture disabled at vsync fall
    run_frame(1'b0, 1'b0);
    line_len = {8, 8};      // capture_en dropped mid-frame
    run_frame(1'b1, 1'b1);

    for (int f = 0; f < 6; f++) begin
      line_len = {};
      for (int l = 0; l < $urandom_range(1, 3); l++) line_len.push_back($urandom_range(0, 10));
      run_frame(1'($urandom_range(0, 1)), 1'b0);
    end

    // reset asserted mid-frame
    @(negedge clk);
    capture_en = 1'b1;
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("busy_async_rst", 64'(busy), 64'(0));
    cam_href = 1'b1;
    cam_byte(8'hA5, 1'b0);
    cam_byte(8'h5A, 1'b1);
    end_line();
    reset_n = 1'b1;
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'(exp_done));
    check("rst_mid_queue", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
